bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the BCD adder and turns binary operands into packed BCD digit vectors for it.
- Replaces combinational decimal-to-BCD conversion in the datapath with a small, multi-cycle, area-cheap block.
- Uses a start/ready/valid handshake; one conversion in flight at a time.

Parameters:
- BIN_W, 11, width of the binary input in bits; also the number of shift cycles.
- DIGITS, 4, number of BCD digits produced; output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only while ready=1.
- bin_in  input  BIN_W  unsigned binary operand; captured on the accepted start.
- ready  output  1  block is idle and can accept start.
- valid  output  1  one-cycle pulse; bcd_out and overflow are new this cycle.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]. Held until the next valid.
- overflow  output  1  result does not fit in DIGITS digits; qualified with bcd_out, held likewise.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, ready=1, valid=0, bcd_out=0, overflow=0, internal registers cleared.
- States:
  - IDLE: ready=1. On start=1, load the binary shift register with bin_in, clear the BCD register, clear the sticky overflow flag, set cnt=0, and go to SHIFT. If start=0, stay in IDLE.
  - SHIFT: ready=0. Each cycle:
    - every BCD digit >=5 gets +3 (values 5..9 map to 8..12);
    - then the combined {bcd, bin} register shifts left by 1;
    - if the bit leaving the BCD MSB is 1, the sticky overflow flag is set;
    - cnt increments.
    - After exactly BIN_W shift cycles, go to DONE.
  - DONE: lasts one cycle. valid=1, bcd_out and overflow are registered from the working registers, ready=0. Next state is IDLE.
- Latency: start accepted in cycle N gives valid in cycle N+BIN_W+1. The next start can be accepted in cycle N+BIN_W+2.
- Throughput: one conversion per BIN_W+2 cycles.
- start while ready=0 (SHIFT or DONE) is ignored. It is not queued, and bin_in changes during SHIFT have no effect.
- start held high continuously gives back-to-back conversions, each sampling bin_in on its acceptance cycle.
- Digit correction is applied before every shift, including the first; the step after the last shift gets no correction.
- bcd_out digits are always 0..9 when overflow=0. When overflow=1, bcd_out holds the low DIGITS digits and its contents are not otherwise specified.
- Counter cnt is $clog2(BIN_W+1) bits wide and never wraps in normal operation.
- Reset mid-conversion: the next cycle is IDLE with all outputs at their reset values. No valid is emitted for the aborted conversion.
- rst has priority over start in the same cycle.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W = 4;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE (2-bit);
  - function digits_needed(bin_w), used by benches to choose a DIGITS value that cannot overflow.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >=5 add 3" cell.
  - Instantiated DIGITS times by generate.
  - The BCD adder's own correction logic can reuse it.

Test Plan:
- Reset then bin_in=0, start pulse: ready drops next cycle; valid pulses 12 cycles after start with bcd_out=16'h0000, overflow=0; ready returns the cycle after.
- bin_in=999, start: valid at +12 with bcd_out=16'h0999. Then bin_in=1998: bcd_out=16'h1998. Then bin_in=2047 (max): bcd_out=16'h2047. overflow=0 for all three.
- Convert 457. During SHIFT, pulse start with bin_in=123 and change bin_in every cycle: exactly one valid, bcd_out=16'h0457; the ignored start produces no second valid.
- start held high with bin_in=5, then 10: consecutive valids 13 cycles apart, bcd_out=16'h0005 then 16'h0010.
- Assert rst 5 cycles into a conversion of 1500: no valid; ready=1, bcd_out=0 on the following cycle. A fresh conversion of 42 then gives 16'h0042.
- Instance with DIGITS=3, BIN_W=11 and bin_in=1234: valid at +12 with overflow=1. Then bin_in=999: overflow=0, bcd_out=12'h999. Also exhaustive 0..2047 versus a reference model, with zero mismatches.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD converter and its BCD neighbours.
//   BCD_DIGIT_W    width of one packed BCD digit
//   ST_*           2-bit state encoding of the sequential converter
//   digits_needed  decimal digits required to hold any unsigned bin_w-bit value
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of decimal digits of (2**bin_w - 1); at least one digit.
    function automatic int unsigned digits_needed(input int unsigned bin_w);
        logic [127:0] v;
        int unsigned  d;
        v = (128'd1 << bin_w) - 128'd1;
        d = 1;
        for (int i = 0; i < 40; i++) begin
            if (v >= 128'd10) begin
                v = v / 128'd10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell: a digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next decimal digit.
//   digit     input  4  BCD digit before correction
//   adjusted  output 4  digit after the conditional +3
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Multi-cycle binary-to-BCD converter (shift-and-add-3). One conversion in
// flight; takes BIN_W shift cycles plus one DONE cycle.
//   clk       input           system clock, rising edge
//   rst       input           synchronous active-high reset
//   start     input           conversion request, accepted only while ready
//   bin_in    input  BIN_W    unsigned operand, captured on the accepted start
//   ready     output          idle, start will be accepted
//   valid     output          one-cycle pulse, bcd_out/overflow are new
//   bcd_out   output 4*DIGITS packed BCD result, digit 0 in [3:0], held
//   overflow  output          value needed more than DIGITS digits, held
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 11,
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          ready,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
    logic             overflow_q, overflow_d;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shift;
    logic [BIN_W-1:0] bin_shift;
    logic             shift_out;
    logic             last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // {bcd, bin} shifted left by one after correction; the bit pushed out of
    // the top digit would belong to digit DIGITS, so it marks overflow.
    always_comb begin
        bcd_shift  = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_shift  = bin_q << 1;
        shift_out  = bcd_adj[BCD_W-1];
        last_shift = (cnt_q == CNT_W'(BIN_W - 1));
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                ovf_d = ovf_q | shift_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    // Result registers load on the edge into DONE so they are
                    // already new in the valid cycle.
                    bcd_out_d  = bcd_shift;
                    overflow_d = ovf_q | shift_out;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        ready    = (state_q == ST_IDLE);
        valid    = (state_q == ST_DONE);
        bcd_out  = bcd_out_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed and randomized checks of bin_to_bcd_seq against a decimal reference
// model. Instance a uses enough digits for BIN_W, instance b uses 3 digits.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    localparam int unsigned BIN_W = 11;
    localparam int unsigned DA    = digits_needed(BIN_W);
    localparam int unsigned DB    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_a, start_b;
    logic [BIN_W-1:0]  bin_a, bin_b;
    logic              ready_a, ready_b, valid_a, valid_b, ovf_a, ovf_b;
    logic [4*DA-1:0]   bcd_a;
    logic [4*DB-1:0]   bcd_b;

    int n_cmp = 0;
    int n_mis = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DA)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .bin_in   (bin_a),
        .ready    (ready_a),
        .valid    (valid_a),
        .bcd_out  (bcd_a),
        .overflow (ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DB)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .bin_in   (bin_b),
        .ready    (ready_b),
        .valid    (valid_b),
        .bcd_out  (bcd_b),
        .overflow (ovf_b)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by division, packed four bits per digit.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned digits);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(digits); i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int unsigned digits);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(digits); i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion on instance a (sel=0) or b (sel=1), checked end to end.
    task automatic conv_check(input bit sel, input int unsigned v, input string tag);
        int          lat;
        logic [31:0] got_bcd;
        logic        got_ovf;
        logic        rdy_after;
        int unsigned digits;
        logic [31:0] vv;
        digits    = sel ? DB : DA;
        vv        = v;
        lat       = -1;
        got_bcd   = '0;
        got_ovf   = 1'b0;
        rdy_after = 1'b1;
        check({tag, "_ready_idle"}, sel ? ready_b : ready_a, 32'd1);
        if (sel) begin
            start_b = 1'b1;
            bin_b   = vv[BIN_W-1:0];
        end else begin
            start_a = 1'b1;
            bin_a   = vv[BIN_W-1:0];
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            if (k == 1) rdy_after = sel ? ready_b : ready_a;
            if (sel ? valid_b : valid_a) begin
                lat     = k;
                got_bcd = sel ? 32'(bcd_b) : 32'(bcd_a);
                got_ovf = sel ? ovf_b : ovf_a;
                break;
            end
        end
        check({tag, "_ready_drop"}, 32'(rdy_after), 32'd0);
        check({tag, "_latency"}, lat, BIN_W + 1);
        check({tag, "_overflow"}, 32'(got_ovf), 32'(ref_ovf(v, digits)));
        if (!ref_ovf(v, digits)) check({tag, "_bcd"}, got_bcd, ref_bcd(v, digits));
        tick();
        check({tag, "_valid_pulse"}, sel ? valid_b : valid_a, 32'd0);
        check({tag, "_ready_back"}, sel ? ready_b : ready_a, 32'd1);
    endtask

    initial begin
        int          nval;
        int          t1, t2;
        logic [31:0] got, b1, b2;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = '0;
        bin_b   = '0;
        tick();
        tick();
        check("rst_ready", ready_a, 32'd1);
        check("rst_valid", valid_a, 32'd0);
        check("rst_bcd", bcd_a, 32'd0);
        check("rst_ovf", ovf_a, 32'd0);
        rst = 1'b0;
        tick();

        conv_check(1'b0, 0, "zero");
        conv_check(1'b0, 999, "v999");
        conv_check(1'b0, 1998, "v1998");
        conv_check(1'b0, 2047, "v2047");
        check("v2047_const", bcd_a, 32'h2047);

        // Start pulses and bin_in churn during SHIFT must be ignored.
        start_a = 1'b1;
        bin_a   = 11'd457;
        nval    = 0;
        got     = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) start_a = 1'b0;
            if (k == 3) begin
                start_a = 1'b1;
                bin_a   = 11'd123;
            end else if (k > 3 && k < 10) begin
                bin_a = BIN_W'($urandom);
            end
            if (k == 10) start_a = 1'b0;
            if (valid_a) begin
                nval++;
                got = 32'(bcd_a);
            end
        end
        check("ignore_count", nval, 32'd1);
        check("ignore_bcd", got, ref_bcd(457, DA));

        // start held high: back-to-back conversions.
        start_a = 1'b1;
        bin_a   = 11'd5;
        t1      = -1;
        t2      = -1;
        b1      = '0;
        b2      = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) bin_a = 11'd10;
            if (valid_a) begin
                if (t1 < 0) begin
                    t1 = k;
                    b1 = 32'(bcd_a);
                end else begin
                    t2 = k;
                    b2 = 32'(bcd_a);
                    break;
                end
            end
        end
        start_a = 1'b0;
        check("b2b_first_lat", t1, BIN_W + 1);
        check("b2b_spacing", t2 - t1, BIN_W + 2);
        check("b2b_bcd0", b1, ref_bcd(5, DA));
        check("b2b_bcd1", b2, ref_bcd(10, DA));
        tick();

        // Reset five cycles into a conversion; rst also wins over a start.
        start_a = 1'b1;
        bin_a   = 11'd1500;
        nval    = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) start_a = 1'b0;
            if (valid_a) nval++;
        end
        rst     = 1'b1;
        start_a = 1'b1;
        bin_a   = 11'd7;
        tick();
        rst     = 1'b0;
        start_a = 1'b0;
        check("abort_ready", ready_a, 32'd1);
        check("abort_valid", valid_a, 32'd0);
        check("abort_bcd", bcd_a, 32'd0);
        check("abort_ovf", ovf_a, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (valid_a) nval++;
        end
        check("abort_no_valid", nval, 32'd0);
        conv_check(1'b0, 42, "after_abort");

        for (int i = 0; i < 40; i++) begin
            conv_check(1'b0, $urandom_range(2047, 0), $sformatf("rand%0d", i));
        end

        // Three-digit instance: overflow boundary then exhaustive sweep.
        conv_check(1'b1, 1234, "d3_1234");
        check("d3_1234_ovf_const", ovf_b, 32'd1);
        conv_check(1'b1, 999, "d3_999");
        check("d3_999_const", bcd_b, 32'h999);
        for (int v = 0; v < 2048; v++) begin
            conv_check(1'b1, v, $sformatf("exh%0d", v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
